dti_fifo_async_sf_w1rm: RTL and testbench
=========================================

DTI_FIFO_ASYNC_SF_W1RM -- requirements
Module: dti_fifo_async_sf_w1rm

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameters SHALL be WR_DATA_WIDTH, 8, write byte width; RD_DATA_WIDTH, 128, read word width (=16*WR_DATA_WIDTH); DEPTH, 32, capacity in bytes (power of 2, >=16); SRAM_OR_FF, 0, storage select (0=flops; only 0 is supported).
REQ-003 Let LW = floor_log2(DEPTH); occupancy count is LW+1 bits.
REQ-004 Ports SHALL be:
  clk  in  1  sole clock (both sides);
  reset_n  in  1  async active-low reset;
  wr_req  in  1  push one byte;
  wr_din  in  WR_DATA_WIDTH  byte to push;
  wr_full, wr_empty, wr_empty_synced  out  1  write-side status;
  wr_prog_full, wr_prog_empty  out  1  programmable flags;
  wr_prog_full_lvl, wr_prog_empty_lvl  in  LW  thresholds;
  wr_error  out  1  overflow pulse;
  rd_req  in  1  pop one packet;
  rd_dout  out  RD_DATA_WIDTH  head packet;
  rd_empty, rd_full, rd_full_synced  out  1  read-side status;
  rd_prog_empty, rd_prog_full  out  1  programmable flags;
  rd_prog_empty_lvl, rd_prog_full_lvl  in  LW  thresholds;
  rd_error  out  1  underflow pulse;
  pop_mode  out  2  size code of head packet.

Function
REQ-005 Write: wr_req=1 and wr_full=0 stores wr_din at write pointer; pointer +1 (mod DEPTH); count +1.
REQ-006 wr_req=1 while wr_full=1: byte dropped, nothing changes, wr_error=1 next cycle for one cycle.
REQ-007 Stream is packets; first byte of each packet is a header; pop_mode = header[1:0] of byte at read pointer, combinational.
REQ-008 Packet size N bytes (header included): pop_mode 0->1, 1->4, 2->8, 3->16.
REQ-009 Store-and-forward: rd_empty=1 whenever count < N (count=0 included).
REQ-010 rd_dout combinational (first-word fall-through): byte k of packet (k=0 header) on bits [8k+7:8k] for k<N; remaining bits 0; reads wrap modulo DEPTH.
REQ-011 Pop: rd_req=1 and rd_empty=0 advances read pointer by N (mod DEPTH); count -N.
REQ-012 rd_req=1 while rd_empty=1: no change; rd_error=1 next cycle for one cycle.
REQ-013 Simultaneous valid push and pop in one cycle: count = count+1-N; both take effect.
REQ-014 wr_full = rd_full = (count==DEPTH); wr_empty = (count==0).
REQ-015 x_prog_full = (count >= x_prog_full_lvl); x_prog_empty = (count <= x_prog_empty_lvl); x in {wr, rd}, each side's own thresholds.
REQ-016 wr_empty_synced = wr_empty and rd_full_synced = rd_full, each delayed by one register stage.
REQ-017 Flags other than *_synced and *_error are combinational from registered count/pointers.

Reset
REQ-018 reset_n low SHALL clear pointers and count immediately; data storage not cleared.
REQ-019 Reset values: wr_empty=1, wr_empty_synced=1, rd_empty=1, wr_full=rd_full=rd_full_synced=0, wr_error=rd_error=0, rd_dout=0, prog flags per REQ-015 with count=0.
REQ-020 Reset mid-packet discards all contents; next byte written is treated as a header.

Structure
REQ-021 Package dti_fifo_pkg SHALL hold floor_log2 function, pop_mode encoding constants, and pop_mode-to-N function.
REQ-022 One sub-module dti_fifo_w1rm_mem: DEPTH x WR_DATA_WIDTH flop array, one write port, 16 combinational read taps from a base address.

Verification
REQ-023 Reset, no traffic -> wr_empty=rd_empty=1, wr_full=0, wr_error=rd_error=0.
REQ-024 Push 0x12 + 7 random bytes, rd_req=0 -> rd_empty=1 until 8th byte written, then 0; pop_mode=2; rd_dout[63:0]=packet, [127:64]=0.
REQ-025 Push 0x12x8, 0x1Bx16, 0x12x8 (32 bytes) -> wr_full=rd_full=1 after 32nd byte, rd_full_synced one cycle later; 33rd push -> wr_error pulse, contents unchanged.
REQ-026 From REQ-025 state, rd_req=1 one cycle -> count 24, pop_mode=3, rd_dout = 16-byte packet.
REQ-027 rd_req=1 with count 3 and head pop_mode=1 -> rd_error pulse, count stays 3.
REQ-028 wr_prog_full_lvl=20, wr_prog_empty_lvl=4 -> wr_prog_full set at count 20, wr_prog_empty cleared at count 5; pointer wrap past 31 keeps data intact.

Source files
------------

// File: rtl/dti_fifo_pkg.sv
// dti_fifo_pkg
//   Shared definitions for the byte-in / packet-out store-and-forward FIFO.
//   - floor_log2     : constant function that sizes pointers and occupancy counters
//   - POP_MODE_*     : header size codes carried in bits [1:0] of each packet header
//   - pop_mode_to_n  : number of bytes in a packet (header included) for a size code
package dti_fifo_pkg;

  localparam logic [1:0] POP_MODE_1B  = 2'd0;
  localparam logic [1:0] POP_MODE_4B  = 2'd1;
  localparam logic [1:0] POP_MODE_8B  = 2'd2;
  localparam logic [1:0] POP_MODE_16B = 2'd3;

  // Largest packet the read side can present in one word.
  localparam int MAX_PKT_BYTES = 16;

  function automatic int floor_log2(input int value);
    int result;
    result = 0;
    for (int i = 1; i < 31; i++) begin
      if (value >= (1 << i)) result = i;
    end
    return result;
  endfunction

  function automatic logic [4:0] pop_mode_to_n(input logic [1:0] mode);
    logic [4:0] n;
    case (mode)
      POP_MODE_1B: n = 5'd1;
      POP_MODE_4B: n = 5'd4;
      POP_MODE_8B: n = 5'd8;
      default:     n = 5'd16;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dti_fifo_w1rm_mem.sv
// dti_fifo_w1rm_mem
//   DEPTH x WR_DATA_WIDTH flop storage with one synchronous write port and
//   MAX_PKT_BYTES combinational read taps starting at rd_base. Tap addresses
//   wrap modulo DEPTH so a packet may straddle the end of the array.
//   Storage is deliberately not reset.
// Ports:
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - byte to store
//   rd_base  - address of tap 0
//   rd_taps  - tap k on bits [k*WR_DATA_WIDTH +: WR_DATA_WIDTH]
module dti_fifo_w1rm_mem
  import dti_fifo_pkg::*;
#(
  parameter int   WR_DATA_WIDTH = 8,
  parameter int   DEPTH         = 32,
  localparam int  LW            = floor_log2(DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   wr_en,
  input  logic [LW-1:0]                          wr_addr,
  input  logic [WR_DATA_WIDTH-1:0]               wr_data,
  input  logic [LW-1:0]                          rd_base,
  output logic [MAX_PKT_BYTES*WR_DATA_WIDTH-1:0] rd_taps
);

  logic [WR_DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  for (genvar k = 0; k < MAX_PKT_BYTES; k++) begin : g_tap
    logic [LW-1:0] tap_addr;
    assign tap_addr = rd_base + LW'(k);
    assign rd_taps[k*WR_DATA_WIDTH +: WR_DATA_WIDTH] = mem_q[tap_addr];
  end

endmodule

// File: rtl/dti_fifo_async_sf_w1rm.sv
// dti_fifo_async_sf_w1rm
//   Single-clock store-and-forward FIFO: bytes are pushed one per cycle, whole
//   packets are popped one per cycle. The byte at the read pointer is a header
//   whose bits [1:0] give the packet size (1/4/8/16 bytes). The read side only
//   reports non-empty once the complete head packet is stored, and presents it
//   first-word-fall-through on rd_dout (unused upper bytes zero).
// Ports:
//   clk, reset_n                       - clock, async active-low reset
//   wr_req, wr_din                     - push one byte
//   wr_full, wr_empty, wr_empty_synced - write-side status (synced = 1 cycle late)
//   wr_prog_full/empty, *_lvl          - write-side programmable thresholds
//   wr_error                           - one-cycle pulse after a push into a full FIFO
//   rd_req, rd_dout, pop_mode          - pop one packet, head packet, its size code
//   rd_empty, rd_full, rd_full_synced  - read-side status (synced = 1 cycle late)
//   rd_prog_empty/full, *_lvl          - read-side programmable thresholds
//   rd_error                           - one-cycle pulse after a pop while empty
module dti_fifo_async_sf_w1rm
  import dti_fifo_pkg::*;
#(
  parameter int  WR_DATA_WIDTH = 8,
  parameter int  RD_DATA_WIDTH = 128,
  parameter int  DEPTH         = 32,
  parameter int  SRAM_OR_FF    = 0,
  localparam int LW            = floor_log2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_req,
  input  logic [WR_DATA_WIDTH-1:0] wr_din,
  output logic                     wr_full,
  output logic                     wr_empty,
  output logic                     wr_empty_synced,
  output logic                     wr_prog_full,
  output logic                     wr_prog_empty,
  input  logic [LW-1:0]            wr_prog_full_lvl,
  input  logic [LW-1:0]            wr_prog_empty_lvl,
  output logic                     wr_error,
  input  logic                     rd_req,
  output logic [RD_DATA_WIDTH-1:0] rd_dout,
  output logic                     rd_empty,
  output logic                     rd_full,
  output logic                     rd_full_synced,
  output logic                     rd_prog_empty,
  output logic                     rd_prog_full,
  input  logic [LW-1:0]            rd_prog_empty_lvl,
  input  logic [LW-1:0]            rd_prog_full_lvl,
  output logic                     rd_error,
  output logic [1:0]               pop_mode
);

  if (SRAM_OR_FF != 0) begin : g_chk_storage
    $error("dti_fifo_async_sf_w1rm: only flop storage (SRAM_OR_FF=0) is implemented");
  end
  if (RD_DATA_WIDTH != MAX_PKT_BYTES * WR_DATA_WIDTH) begin : g_chk_width
    $error("dti_fifo_async_sf_w1rm: RD_DATA_WIDTH must be 16*WR_DATA_WIDTH");
  end

  localparam logic [LW:0] FULL_CNT = (LW+1)'(DEPTH);

  logic [LW-1:0] wr_ptr_q;
  logic [LW-1:0] rd_ptr_q;
  logic [LW:0]   count_q;
  logic [LW:0]   count_nxt;
  logic [LW:0]   pkt_n;
  logic          push;
  logic          pop;
  logic          wr_empty_p1;
  logic          rd_full_p1;
  logic          wr_error_p1;
  logic          rd_error_p1;
  logic [MAX_PKT_BYTES*WR_DATA_WIDTH-1:0] taps;

  dti_fifo_w1rm_mem #(
    .WR_DATA_WIDTH (WR_DATA_WIDTH),
    .DEPTH         (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_din),
    .rd_base (rd_ptr_q),
    .rd_taps (taps)
  );

  assign pop_mode = taps[1:0];
  assign pkt_n    = (LW+1)'(pop_mode_to_n(pop_mode));

  assign wr_full  = (count_q == FULL_CNT);
  assign rd_full  = wr_full;
  assign wr_empty = (count_q == '0);
  // Store-and-forward: the head packet is visible only once fully stored.
  assign rd_empty = (count_q < pkt_n);

  assign push = wr_req & ~wr_full;
  assign pop  = rd_req & ~rd_empty;

  assign count_nxt = count_q + {{LW{1'b0}}, push} - (pop ? pkt_n : '0);

  assign wr_prog_full  = (count_q >= {1'b0, wr_prog_full_lvl});
  assign wr_prog_empty = (count_q <= {1'b0, wr_prog_empty_lvl});
  assign rd_prog_full  = (count_q >= {1'b0, rd_prog_full_lvl});
  assign rd_prog_empty = (count_q <= {1'b0, rd_prog_empty_lvl});

  // Bytes beyond the head packet are masked; an empty FIFO shows zero so stale
  // storage never appears on the output after reset.
  always_comb begin
    rd_dout = '0;
    if (!wr_empty) begin
      for (int k = 0; k < MAX_PKT_BYTES; k++) begin
        if ((LW+1)'(k) < pkt_n) begin
          rd_dout[k*WR_DATA_WIDTH +: WR_DATA_WIDTH] = taps[k*WR_DATA_WIDTH +: WR_DATA_WIDTH];
        end
      end
    end
  end

  // Stage p0 -> p1: pointer/count update, error pulses and one-cycle-late status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_empty_p1 <= 1'b1;
      rd_full_p1  <= 1'b0;
      wr_error_p1 <= 1'b0;
      rd_error_p1 <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + pkt_n[LW-1:0];
      count_q     <= count_nxt;
      wr_empty_p1 <= wr_empty;
      rd_full_p1  <= rd_full;
      wr_error_p1 <= wr_req & wr_full;
      rd_error_p1 <= rd_req & rd_empty;
    end
  end

  assign wr_empty_synced = wr_empty_p1;
  assign rd_full_synced  = rd_full_p1;
  assign wr_error        = wr_error_p1;
  assign rd_error        = rd_error_p1;

endmodule

// File: tb/tb_dti_fifo_async_sf_w1rm.sv
module tb_dti_fifo_async_sf_w1rm;

  localparam int W  = 8;
  localparam int RW = 128;
  localparam int D  = 32;
  localparam int LW = 5;

  logic          clk;
  logic          reset_n;
  logic          wr_req;
  logic [W-1:0]  wr_din;
  logic          wr_full, wr_empty, wr_empty_synced;
  logic          wr_prog_full, wr_prog_empty;
  logic [LW-1:0] wr_prog_full_lvl, wr_prog_empty_lvl;
  logic          wr_error;
  logic          rd_req;
  logic [RW-1:0] rd_dout;
  logic          rd_empty, rd_full, rd_full_synced;
  logic          rd_prog_empty, rd_prog_full;
  logic [LW-1:0] rd_prog_empty_lvl, rd_prog_full_lvl;
  logic          rd_error;
  logic [1:0]    pop_mode;

  int checks = 0;
  int errors = 0;

  dti_fifo_async_sf_w1rm #(
    .WR_DATA_WIDTH (W),
    .RD_DATA_WIDTH (RW),
    .DEPTH         (D),
    .SRAM_OR_FF    (0)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .wr_req            (wr_req),
    .wr_din            (wr_din),
    .wr_full           (wr_full),
    .wr_empty          (wr_empty),
    .wr_empty_synced   (wr_empty_synced),
    .wr_prog_full      (wr_prog_full),
    .wr_prog_empty     (wr_prog_empty),
    .wr_prog_full_lvl  (wr_prog_full_lvl),
    .wr_prog_empty_lvl (wr_prog_empty_lvl),
    .wr_error          (wr_error),
    .rd_req            (rd_req),
    .rd_dout           (rd_dout),
    .rd_empty          (rd_empty),
    .rd_full           (rd_full),
    .rd_full_synced    (rd_full_synced),
    .rd_prog_empty     (rd_prog_empty),
    .rd_prog_full      (rd_prog_full),
    .rd_prog_empty_lvl (rd_prog_empty_lvl),
    .rd_prog_full_lvl  (rd_prog_full_lvl),
    .rd_error          (rd_error),
    .pop_mode          (pop_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each task spans exactly one rising edge and returns 1 time unit after it.
  task automatic push(input logic [7:0] b);
    wr_req = 1'b1;
    wr_din = b;
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic pop_req();
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] fill_byte(input int j);
    if (j == 0)       return 8'h12;
    else if (j < 8)   return 8'hB0 + 8'(j);
    else if (j == 8)  return 8'h1B;
    else if (j < 24)  return 8'hC0 + 8'(j - 8);
    else if (j == 24) return 8'h12;
    else              return 8'hD0 + 8'(j - 24);
  endfunction

  initial begin
    reset_n           = 1'b0;
    wr_req            = 1'b0;
    wr_din            = '0;
    rd_req            = 1'b0;
    wr_prog_full_lvl  = 5'd20;
    wr_prog_empty_lvl = 5'd4;
    rd_prog_full_lvl  = 5'd16;
    rd_prog_empty_lvl = 5'd2;

    // Reset state, no traffic.
    #12;
    chk("rst_wr_empty", wr_empty, 1'b1);
    chk("rst_rd_empty", rd_empty, 1'b1);
    chk("rst_wr_full", wr_full, 1'b0);
    chk("rst_rd_full", rd_full, 1'b0);
    chk("rst_wr_empty_synced", wr_empty_synced, 1'b1);
    chk("rst_rd_full_synced", rd_full_synced, 1'b0);
    chk("rst_wr_error", wr_error, 1'b0);
    chk("rst_rd_error", rd_error, 1'b0);
    chk("rst_rd_dout", rd_dout, 128'h0);
    chk("rst_wr_prog_empty", wr_prog_empty, 1'b1);
    chk("rst_wr_prog_full", wr_prog_full, 1'b0);
    chk("rst_rd_prog_empty", rd_prog_empty, 1'b1);
    chk("rst_rd_prog_full", rd_prog_full, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle();

    // One 8-byte packet: held back until its last byte lands.
    for (int i = 0; i < 8; i++) begin
      push((i == 0) ? 8'h12 : 8'hA0 + 8'(i));
      if (i == 0) begin
        chk("a_wr_empty", wr_empty, 1'b0);
        chk("a_wr_empty_synced_lag", wr_empty_synced, 1'b1);
      end
      if (i == 1) chk("a_wr_empty_synced", wr_empty_synced, 1'b0);
      if (i == 6) chk("a_rd_empty_7", rd_empty, 1'b1);
    end
    chk("a_rd_empty_8", rd_empty, 1'b0);
    chk("a_pop_mode", pop_mode, 2'd2);
    chk("a_rd_dout", rd_dout, 128'hA7A6A5A4A3A2A1_12);
    pop_req();
    chk("a_pop_wr_empty", wr_empty, 1'b1);
    chk("a_pop_rd_empty", rd_empty, 1'b1);
    chk("a_pop_rd_error", rd_error, 1'b0);

    // Fill to 32 bytes from pointer 8 (wraps past 31) with 8 + 16 + 8 byte packets.
    for (int j = 0; j < 32; j++) begin
      push(fill_byte(j));
      if (j == 3)  chk("b_prog_empty_cnt4", wr_prog_empty, 1'b1);
      if (j == 4)  chk("b_prog_empty_cnt5", wr_prog_empty, 1'b0);
      if (j == 18) chk("b_prog_full_cnt19", wr_prog_full, 1'b0);
      if (j == 19) chk("b_prog_full_cnt20", wr_prog_full, 1'b1);
      if (j == 30) chk("b_wr_full_cnt31", wr_full, 1'b0);
    end
    chk("b_wr_full", wr_full, 1'b1);
    chk("b_rd_full", rd_full, 1'b1);
    chk("b_rd_full_synced_lag", rd_full_synced, 1'b0);
    chk("b_rd_prog_full", rd_prog_full, 1'b1);
    chk("b_rd_prog_empty", rd_prog_empty, 1'b0);
    idle();
    chk("b_rd_full_synced", rd_full_synced, 1'b1);
    push(8'hEE);
    chk("b_wr_error", wr_error, 1'b1);
    chk("b_full_after_drop", wr_full, 1'b1);
    idle();
    chk("b_wr_error_clear", wr_error, 1'b0);
    chk("b_head_mode", pop_mode, 2'd2);
    chk("b_head_dout", rd_dout, 128'hB7B6B5B4B3B2B1_12);

    // Pop the first packet: count 24, 16-byte packet at the head.
    pop_req();
    chk("c_pop_mode", pop_mode, 2'd3);
    chk("c_rd_dout", rd_dout, 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1_1B);
    chk("c_wr_full", wr_full, 1'b0);
    chk("c_rd_full", rd_full, 1'b0);
    chk("c_rd_full_synced", rd_full_synced, 1'b1);
    chk("c_wr_prog_full", wr_prog_full, 1'b1);

    // Simultaneous push (header 0x11, 4-byte packet) and 16-byte pop: count 9.
    wr_req = 1'b1;
    wr_din = 8'h11;
    rd_req = 1'b1;
    @(posedge clk); #1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    chk("d_pop_mode", pop_mode, 2'd2);
    chk("d_rd_dout", rd_dout, 128'hD7D6D5D4D3D2D1_12);
    chk("d_rd_empty", rd_empty, 1'b0);
    chk("d_wr_prog_full", wr_prog_full, 1'b0);
    chk("d_wr_prog_empty", wr_prog_empty, 1'b0);
    chk("d_rd_prog_empty", rd_prog_empty, 1'b0);

    // Pop the wrapped packet: count 1, head needs 4 bytes.
    pop_req();
    chk("e_pop_mode", pop_mode, 2'd1);
    chk("e_rd_empty", rd_empty, 1'b1);
    chk("e_wr_prog_empty", wr_prog_empty, 1'b1);
    chk("e_rd_prog_empty", rd_prog_empty, 1'b1);
    push(8'h21);
    push(8'h22);
    // Count 3 with a 4-byte head: underflow.
    pop_req();
    chk("e_rd_error", rd_error, 1'b1);
    chk("e_rd_empty_after", rd_empty, 1'b1);
    idle();
    chk("e_rd_error_clear", rd_error, 1'b0);
    push(8'h23);
    chk("e_rd_empty_cnt4", rd_empty, 1'b0);
    chk("e_rd_dout", rd_dout, 128'h23222111);

    // Reset mid-stream discards everything; next byte is a header.
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("f_rst_wr_empty", wr_empty, 1'b1);
    chk("f_rst_rd_empty", rd_empty, 1'b1);
    chk("f_rst_rd_dout", rd_dout, 128'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    push(8'h10);
    chk("f_rd_empty", rd_empty, 1'b0);
    chk("f_pop_mode", pop_mode, 2'd0);
    chk("f_rd_dout", rd_dout, 128'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
